bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, is the number of BUSY cycles without s_ready before the arbiter aborts the transaction.
REQ-002 Parameter ERR_DATA, default 32'hFFFFFFFF, is the read data returned on timeout or on an unmapped access.
REQ-003 clk  input  1  system clock; the only clock.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 m0_addr, m1_addr  input  32 each  master byte address (m0 = CPU, m1 = DMA).
REQ-006 m0_wdata, m1_wdata  input  32 each  master write data.
REQ-007 m0_lane, m1_lane  input  4 each  byte enables.
REQ-008 m0_wr, m1_wr  input  1 each  1 = write, 0 = read.
REQ-009 m0_valid, m1_valid  input  1 each  request; held stable until the matching ready.
REQ-010 m0_ready, m1_ready  output  1 each  one-cycle completion pulse.
REQ-011 m0_rdata, m1_rdata  output  32 each  read data, valid while the matching ready is 1.
REQ-012 s_addr, s_wdata, s_lane, s_wr  output  32/32/4/1  registered copy of the granted request.
REQ-013 s_valid  output  1  slave request strobe.
REQ-014 s_sel  output  8  one-hot region select: [0] sram, [1] gpio, [2] uart, [3] vdu_io, [4] timer, [5] seg, [6] spi, [7] sdram.
REQ-015 s_rdata  input  32  read data from the selected slave.
REQ-016 s_ready  input  1  completion from the selected slave.
REQ-017 err  output  1  one-cycle pulse on timeout or unmapped access.
REQ-018 err_addr  output  32  address of the last errored access.

Function
REQ-019 Address decode shall be: addr[31]=1 -> sdram; addr[31:28]=0 -> sram; addr[31:24]=8'h10..8'h15 -> gpio, uart, vdu_io, timer, seg, spi in that order; every other address is unmapped.
REQ-020 The FSM shall have three states: IDLE, BUSY and DONE.
REQ-021 In IDLE with any valid asserted, the arbiter shall grant one master, register its request onto the s_* outputs, set the decoded s_sel, assert s_valid and enter BUSY on the next edge.
REQ-022 Arbitration shall be round-robin: when both masters are valid, grant the master not granted last; after reset, m0 is treated as last-granted-opposite, so m0 wins the first tie.
REQ-023 When a single master is valid, it shall be granted regardless of history.
REQ-024 s_valid and s_sel shall stay constant through BUSY; s_sel shall be all-zero outside BUSY.
REQ-025 In BUSY, s_ready=1 shall capture s_rdata, drop s_valid and enter DONE.
REQ-026 In DONE, exactly the granted master's ready shall be 1 for one cycle with the captured data on its rdata, then the FSM shall return to IDLE.
REQ-027 Minimum latency from valid sampled in IDLE to ready shall be 3 cycles: grant, slave response with s_ready at the first BUSY cycle, DONE.
REQ-028 A BUSY cycle counter shall count up; when it reaches TIMEOUT with no s_ready, the FSM shall drop s_valid, return ERR_DATA, pulse err, load err_addr and enter DONE.
REQ-029 s_ready arriving in the same cycle as the timeout shall win; no err is raised.
REQ-030 An unmapped address shall skip BUSY: s_valid stays 0, the FSM goes IDLE -> DONE with ERR_DATA, err pulses and err_addr is loaded.
REQ-031 Writes shall complete identically to reads; rdata is don't-care for writes but is still driven from the capture register.
REQ-032 A request from the non-granted master shall not be sampled until the next IDLE.
REQ-033 The mandatory IDLE cycle after DONE guarantees that a master's still-asserted valid in the ready cycle is never re-granted.
REQ-034 A valid deasserted by a master during BUSY shall be ignored; the transaction completes normally.

Reset
REQ-035 On rst_n=0 at a clock edge, the arbiter shall reset to the following values: state=IDLE, s_valid=0, s_sel=0, m0_ready=m1_ready=0, err=0, err_addr=0, rdata capture=0, last-grant=m1, counter=0.
REQ-036 Reset mid-transaction shall abort it without a ready pulse; s_valid shall be 0 from the first post-reset cycle.

Structure
REQ-037 Region base constants, s_sel bit indices and the FSM state encoding shall live in a shared package, bus_pkg.
REQ-038 The address decoder shall be a sub-module, bus_decode: combinational, addr in, 8-bit one-hot plus unmapped flag out, reused by other bus blocks.

Verification
REQ-039 m0 reads 0x1300_0000; timer holds s_ready 1 cycle after s_valid with data 0x0000_1234 -> m0_ready pulses 4 cycles after request with m0_rdata=0x0000_1234 and m1_ready=0.
REQ-040 m0 and m1 both valid continuously for 4 transactions -> grant order m0, m1, m0, m1, with s_sel matching each address.
REQ-041 m1 writes 0x8000_0010 with data 0xDEADBEEF and lane 4'b0011; slave never replies (TIMEOUT=8) -> after 8 BUSY cycles, m1_ready=1, err pulses, err_addr=0x8000_0010, s_valid=0.
REQ-042 m0 reads unmapped 0x2000_0000 -> s_valid never rises, m0_rdata=0xFFFFFFFF with m0_ready 2 cycles after request, err pulses.
REQ-043 rst_n driven low during BUSY of an sdram access -> next cycle s_valid=0, no ready pulse; the first request after reset is granted to m0.
REQ-044 s_ready in the exact timeout cycle (TIMEOUT=8, s_ready on BUSY cycle 8) -> normal data returned, err stays 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus definitions: FSM encoding, region base bytes and one-hot select indices.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NUM_REGIONS = 8;

  localparam int SEL_SRAM   = 0;
  localparam int SEL_GPIO   = 1;
  localparam int SEL_UART   = 2;
  localparam int SEL_VDU_IO = 3;
  localparam int SEL_TIMER  = 4;
  localparam int SEL_SEG    = 5;
  localparam int SEL_SPI    = 6;
  localparam int SEL_SDRAM  = 7;

  // sram occupies addr[31:28] == 0; sdram is anything with addr[31] set
  localparam logic [3:0] BASE_SRAM   = 4'h0;
  localparam logic [7:0] BASE_GPIO   = 8'h10;
  localparam logic [7:0] BASE_UART   = 8'h11;
  localparam logic [7:0] BASE_VDU_IO = 8'h12;
  localparam logic [7:0] BASE_TIMER  = 8'h13;
  localparam logic [7:0] BASE_SEG    = 8'h14;
  localparam logic [7:0] BASE_SPI    = 8'h15;

endpackage

// File: rtl/bus_decode.sv
// Combinational address decoder: byte address to one-hot region select plus unmapped flag.
module bus_decode
  import bus_pkg::*;
(
  input  logic [31:0]            addr,
  output logic [NUM_REGIONS-1:0] sel,
  output logic                   unmapped
);

  // sdram takes priority over the top-byte peripheral windows since it owns addr[31]
  always_comb begin
    sel = '0;
    if (addr[31]) begin
      sel[SEL_SDRAM] = 1'b1;
    end else if (addr[31:28] == BASE_SRAM) begin
      sel[SEL_SRAM] = 1'b1;
    end else begin
      case (addr[31:24])
        BASE_GPIO:   sel[SEL_GPIO]   = 1'b1;
        BASE_UART:   sel[SEL_UART]   = 1'b1;
        BASE_VDU_IO: sel[SEL_VDU_IO] = 1'b1;
        BASE_TIMER:  sel[SEL_TIMER]  = 1'b1;
        BASE_SEG:    sel[SEL_SEG]    = 1'b1;
        BASE_SPI:    sel[SEL_SPI]    = 1'b1;
        default:     ;
      endcase
    end
    unmapped = (sel == '0);
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with address decode, slave timeout and error reporting.
//
//   state | meaning
//   IDLE  | waiting for a master request; grants and registers it
//   BUSY  | request presented to slave; waiting for s_ready or timeout
//   DONE  | one-cycle ready pulse to the granted master
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            m0_addr,
  input  logic [31:0]            m0_wdata,
  input  logic [3:0]             m0_lane,
  input  logic                   m0_wr,
  input  logic                   m0_valid,
  output logic                   m0_ready,
  output logic [31:0]            m0_rdata,
  input  logic [31:0]            m1_addr,
  input  logic [31:0]            m1_wdata,
  input  logic [3:0]             m1_lane,
  input  logic                   m1_wr,
  input  logic                   m1_valid,
  output logic                   m1_ready,
  output logic [31:0]            m1_rdata,
  output logic [31:0]            s_addr,
  output logic [31:0]            s_wdata,
  output logic [3:0]             s_lane,
  output logic                   s_wr,
  output logic                   s_valid,
  output logic [NUM_REGIONS-1:0] s_sel,
  input  logic [31:0]            s_rdata,
  input  logic                   s_ready,
  output logic                   err,
  output logic [31:0]            err_addr
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                   state, state_next;
  logic                     last_grant;
  logic                     pick;
  logic                     any_valid;
  logic                     busy_timeout;
  logic [31:0]              req_addr;
  logic [31:0]              req_wdata;
  logic [3:0]               req_lane;
  logic                     req_wr;
  logic [NUM_REGIONS-1:0]   dec_sel;
  logic                     dec_unmapped;
  logic [NUM_REGIONS-1:0]   sel_q;
  logic [31:0]              rdata_q;
  logic                     err_q;
  logic [CNT_W-1:0]         cnt;

  assign any_valid    = m0_valid | m1_valid;
  assign busy_timeout = (state == ST_BUSY) && !s_ready && (cnt == CNT_LAST);

  // Round-robin pick: on a tie the master not granted last wins, otherwise the lone requester
  always_comb begin
    if (m0_valid && m1_valid) pick = ~last_grant;
    else                      pick = m1_valid;
    req_addr  = pick ? m1_addr  : m0_addr;
    req_wdata = pick ? m1_wdata : m0_wdata;
    req_lane  = pick ? m1_lane  : m0_lane;
    req_wr    = pick ? m1_wr    : m0_wr;
  end

  bus_decode u_decode (
    .addr     (req_addr),
    .sel      (dec_sel),
    .unmapped (dec_unmapped)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; unmapped requests bypass BUSY, s_ready beats a same-cycle timeout
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (any_valid) state_next = dec_unmapped ? ST_DONE : ST_BUSY;
      ST_BUSY: if (s_ready || busy_timeout) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request capture, BUSY cycle counter, read-data capture and error recording
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      s_addr     <= '0;
      s_wdata    <= '0;
      s_lane     <= '0;
      s_wr       <= 1'b0;
      sel_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr   <= '0;
      cnt        <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            last_grant <= pick;
            s_addr     <= req_addr;
            s_wdata    <= req_wdata;
            s_lane     <= req_lane;
            s_wr       <= req_wr;
            sel_q      <= dec_sel;
            cnt        <= '0;
            if (dec_unmapped) begin
              rdata_q  <= ERR_DATA;
              err_q    <= 1'b1;
              err_addr <= req_addr;
            end
          end
        end
        ST_BUSY: begin
          cnt <= cnt + 1'b1;
          if (s_ready) begin
            rdata_q <= s_rdata;
          end else if (busy_timeout) begin
            rdata_q  <= ERR_DATA;
            err_q    <= 1'b1;
            err_addr <= s_addr;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; s_sel is only exposed while the slave is being addressed
  always_comb begin
    s_valid  = (state == ST_BUSY);
    s_sel    = (state == ST_BUSY) ? sel_q : '0;
    m0_ready = (state == ST_DONE) && !last_grant;
    m1_ready = (state == ST_DONE) && last_grant;
    m0_rdata = rdata_q;
    m1_rdata = rdata_q;
    err      = err_q;
  end

endmodule
